// File: rtl/keypad_code_checker.sv
// rtl/keypad_code_checker.sv - keypad digit collector, access-code compare and lockout
// Collects CODE_LEN digits, pulses a registered verdict, locks out after MAX_FAILS misses.
module keypad_code_checker #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] SECRET         = 16'h1234,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 1000,
  parameter int                    TIMEOUT_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic       door_status_correct,
  output logic       door_status_incorrect,
  output logic       locked_out,
  output logic [3:0] digit_count,
  output logic [3:0] fail_count
);

  localparam int W   = 4 * CODE_LEN;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENTRY   = 2'd1;
  localparam logic [1:0] LOCKOUT = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  code_reg;
  logic [3:0]    count_q;
  logic [3:0]    fails_q;
  logic [TW-1:0] idle_timer;
  logic [LW-1:0] lock_timer;
  logic          correct_q;
  logic          incorrect_q;

  logic          is_digit;
  logic          is_clear;
  logic [W-1:0]  base_reg;
  logic [3:0]    base_count;
  logic [W-1:0]  next_reg;
  logic [3:0]    next_count;
  logic [3:0]    next_fails;
  logic          complete;
  logic          match;

  // IDLE behaves as an empty entry, so the first digit uses the same shift path.
  always_comb begin
    is_digit   = digit_valid && (digit <= 4'd9);
    is_clear   = digit_valid && (digit == 4'hA);
    base_reg   = (state == ENTRY) ? code_reg : '0;
    base_count = (state == ENTRY) ? count_q : 4'd0;
    next_reg   = (base_reg << 4) | W'(digit);
    next_count = base_count + 4'd1;
    next_fails = fails_q + 4'd1;
    complete   = (next_count == 4'(CODE_LEN));
    match      = (next_reg == SECRET);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      code_reg    <= '0;
      count_q     <= 4'd0;
      fails_q     <= 4'd0;
      idle_timer  <= '0;
      lock_timer  <= '0;
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
    end else begin
      correct_q   <= 1'b0;
      incorrect_q <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (is_digit) begin
            idle_timer <= '0;
            if (complete) begin
              code_reg <= '0;
              count_q  <= 4'd0;
              if (match) begin
                correct_q <= 1'b1;
                fails_q   <= 4'd0;
                state     <= IDLE;
              end else begin
                incorrect_q <= 1'b1;
                fails_q     <= next_fails;
                if (next_fails == 4'(MAX_FAILS)) begin
                  state      <= LOCKOUT;
                  lock_timer <= '0;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              code_reg <= next_reg;
              count_q  <= next_count;
              state    <= ENTRY;
            end
          end else if (is_clear) begin
            code_reg   <= '0;
            count_q    <= 4'd0;
            idle_timer <= '0;
            state      <= IDLE;
          end else if (state == ENTRY) begin
            // Only a digit restarts the timer; unused codes fall through to here.
            if (idle_timer == TW'(TIMEOUT_CYCLES - 1)) begin
              code_reg   <= '0;
              count_q    <= 4'd0;
              idle_timer <= '0;
              state      <= IDLE;
            end else begin
              idle_timer <= idle_timer + 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (lock_timer == LW'(LOCKOUT_CYCLES - 1)) begin
            lock_timer <= '0;
            fails_q    <= 4'd0;
            state      <= IDLE;
          end else begin
            lock_timer <= lock_timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign door_status_correct   = correct_q;
  assign door_status_incorrect = incorrect_q;
  assign locked_out            = (state == LOCKOUT);
  assign digit_count           = count_q;
  assign fail_count            = fails_q;

endmodule

// File: tb/tb_keypad_code_checker.sv
// tb/tb_keypad_code_checker.sv - scoreboard bench for keypad_code_checker
// Reference model tracks the entry as a digit list; a negedge monitor checks the DUT.
module tb_keypad_code_checker;

  localparam int CODE_LEN = 4;
  localparam int MAXF     = 3;
  localparam int LOCKC    = 1000;
  localparam int TOUT     = 500;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       door_status_correct;
  logic       door_status_incorrect;
  logic       locked_out;
  logic [3:0] digit_count;
  logic [3:0] fail_count;

  keypad_code_checker #(
    .CODE_LEN(CODE_LEN), .SECRET(16'h1234), .MAX_FAILS(MAXF),
    .LOCKOUT_CYCLES(LOCKC), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .digit(digit), .digit_valid(digit_valid),
    .door_status_correct(door_status_correct),
    .door_status_incorrect(door_status_incorrect),
    .locked_out(locked_out), .digit_count(digit_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit ok;
    int fails;
    bit locked;
  } pulse_t;

  pulse_t q[$];
  int     ent[$];
  int     sec[4] = '{1, 2, 3, 4};
  int     m_fails = 0;
  int     lock_rem = 0;
  int     idle = 0;
  int     edge_n = 0;
  bit     live = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference: state after the edge that sampled (v, d).
  task automatic model(input bit v, input int d);
    pulse_t p;
    bit ok;
    if (lock_rem > 0) begin
      lock_rem--;
      if (lock_rem == 0) m_fails = 0;
    end else if (v && d <= 9) begin
      ent.push_back(d);
      idle = 0;
      if (ent.size() == CODE_LEN) begin
        ok = 1;
        for (int i = 0; i < CODE_LEN; i++) if (ent[i] != sec[i]) ok = 0;
        if (ok) m_fails = 0;
        else m_fails++;
        if (!ok && m_fails == MAXF) lock_rem = LOCKC;
        p.cyc = edge_n; p.ok = ok; p.fails = m_fails; p.locked = (lock_rem > 0);
        q.push_back(p);
        ent.delete();
      end
    end else if (v && d == 10) begin
      ent.delete();
      idle = 0;
    end else if (ent.size() > 0) begin
      idle++;
      if (idle == TOUT) begin
        ent.delete();
        idle = 0;
      end
    end
  endtask

  task automatic step(input bit v, input int d);
    digit_valid = v;
    digit = 4'(d);
    @(posedge clk);
    #1;
    model(v, d);
    digit_valid = 1'b0;
  endtask

  task automatic press(input int d);
    step(1'b1, d);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    digit_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ent.delete();
    q.delete();
    m_fails = 0;
    lock_rem = 0;
    idle = 0;
    live = 1;
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  always @(negedge clk) begin
    if (live) begin
      pulse_t p;
      while (q.size() > 0 && q[0].cyc < edge_n) begin
        p = q.pop_front();
        chk("missed_pulse", int'(door_status_correct | door_status_incorrect), 1);
      end
      chk("both_pulses", int'(door_status_correct & door_status_incorrect), 0);
      if (door_status_correct || door_status_incorrect) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got correct=%0d incorrect=%0d expected none (edge %0d)",
                   door_status_correct, door_status_incorrect, edge_n);
        end else begin
          p = q.pop_front();
          chk("pulse_cycle", edge_n, p.cyc);
          chk("pulse_correct", int'(door_status_correct), int'(p.ok));
          chk("pulse_incorrect", int'(door_status_incorrect), int'(!p.ok));
          chk("pulse_fail_count", int'(fail_count), p.fails);
          chk("pulse_locked_out", int'(locked_out), int'(p.locked));
        end
      end
      chk("digit_count", int'(digit_count), ent.size());
      chk("fail_count", int'(fail_count), m_fails);
      chk("locked_out", int'(locked_out), int'(lock_rem > 0));
    end
  end

  initial begin
    int r;
    do_reset();
    wait_n(2);
    // correct, wrong, then correct again
    code4(1, 2, 3, 4); wait_n(2);
    code4(1, 2, 3, 5); wait_n(2);
    code4(1, 2, 3, 4); wait_n(2);
    // lockout and recovery
    code4(9, 9, 9, 9); code4(9, 9, 9, 9); code4(9, 9, 9, 9);
    code4(1, 2, 3, 4); press(10);
    wait_n(LOCKC);
    code4(1, 2, 3, 4); wait_n(2);
    // timeout discards partial; then digit exactly on the expiry edge
    press(1); press(2); wait_n(TOUT);
    code4(3, 4, 1, 2); wait_n(2);
    press(1); press(2); wait_n(TOUT - 1); press(3); press(4); wait_n(2);
    // clear and unused keys
    press(1); press(2); press(10); code4(1, 2, 3, 4); wait_n(2);
    press(1); press(11); press(2); press(3); press(4); wait_n(2);
    // back-to-back entries through the verdict cycle
    code4(1, 2, 3, 4); code4(1, 2, 3, 4);
    // reset mid-entry and during lockout
    press(1); press(2); press(3); do_reset(); wait_n(2);
    code4(5, 5, 5, 5); code4(5, 5, 5, 5); code4(5, 5, 5, 5); wait_n(10);
    do_reset(); wait_n(2);
    // randomized keystrokes
    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 5) press(10);
      else if (r < 10) press(11 + $urandom_range(0, 4));
      else if (r < 13) wait_n(TOUT - 3 + $urandom_range(0, 5));
      else if (r < 60) press(sec[ent.size() % CODE_LEN]);
      else press($urandom_range(0, 9));
      wait_n($urandom_range(0, 2));
    end
    wait_n(3);
    chk("pulses_outstanding", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
